// File: rtl/sisc_fetch.sv
// sisc_fetch: autonomous instruction prefetcher for the SISC core.
// Issues one outstanding word request at a time, buffers {instr, pc} pairs
// in a DEPTH-entry FIFO and hands them to the control unit over valid/ready.
// A taken branch flushes the FIFO; an in-flight request that cannot be
// cancelled is completed and its data discarded (DROP state).
module sisc_fetch #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ack,
    input  logic [DATA_W-1:0] im_data,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_instr,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target
);

    localparam int             PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL  = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] fpc, fpc_nx, addr_nx;
    logic              req_nx;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count, count_nx;
    logic              push, pop, room;

    logic [DATA_W-1:0] mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_pc    [DEPTH];

    assign ir_valid = (count != '0);
    assign ir_instr = mem_instr[rd_ptr];
    assign ir_pc    = mem_pc[rd_ptr];

    // A redirect overrides both FIFO ports: acked data is dropped, head is not consumed.
    assign push = (state == REQ) && im_ack && !br_taken;
    assign pop  = ir_valid && ir_ready && !br_taken;

    // Occupancy after this cycle; issue decisions look at this, not the current count.
    always_comb begin
        count_nx = count;
        if (br_taken)
            count_nx = '0;
        else if (push && !pop)
            count_nx = count + 1'b1;
        else if (pop && !push)
            count_nx = count - 1'b1;
        room = (count_nx < FULL);
    end

    // Next state, next fetch address and next fetch PC.
    always_comb begin
        state_nx = state;
        addr_nx  = im_addr;
        fpc_nx   = fpc;
        if (br_taken)
            fpc_nx = br_target;
        case (state)
            IDLE: begin
                if (br_taken) begin
                    state_nx = REQ;
                    addr_nx  = br_target;
                end else if (room) begin
                    state_nx = REQ;
                    addr_nx  = fpc;
                end
            end
            REQ: begin
                if (im_ack) begin
                    if (br_taken) begin
                        addr_nx = br_target;
                    end else begin
                        // im_addr advances even when parking in IDLE so it shows the next PC
                        fpc_nx   = im_addr + 1'b1;
                        addr_nx  = im_addr + 1'b1;
                        state_nx = room ? REQ : IDLE;
                    end
                end else if (br_taken) begin
                    state_nx = DROP;
                end
            end
            DROP: begin
                if (im_ack) begin
                    state_nx = REQ;
                    addr_nx  = fpc_nx;
                end
            end
            default: state_nx = IDLE;
        endcase
        req_nx = (state_nx != IDLE);
    end

    // Control state, request outputs and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state   <= IDLE;
            fpc     <= RESET_PC;
            im_req  <= 1'b0;
            im_addr <= RESET_PC;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            state   <= state_nx;
            fpc     <= fpc_nx;
            im_req  <= req_nx;
            im_addr <= addr_nx;
            count   <= count_nx;
            if (br_taken) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; contents are meaningless outside the valid window, so no reset.
    always_ff @(posedge clk) begin
        if (push && !rst_f) begin
            mem_instr[wr_ptr] <= im_data;
            mem_pc[wr_ptr]    <= im_addr;
        end
    end

endmodule
